// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control FSM: FETCH/DECODE/EXE/MEM/WB with
// combinational decode of Op/Funct into datapath selects and write strobes.
module mc_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   output logic [2:0] ALUControl,
   output logic       ALUSrc,
   output logic [1:0] ExtOp,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic [1:0] PCSrc,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic [2:0] State
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXE    = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_e;

   typedef enum logic [3:0] {
      C_ADDU, C_SUBU, C_SLL, C_JR, C_ORI, C_LUI,
      C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL
   } cls_e;

   state_e     state_q, state_d;
   cls_e       cls;
   logic [2:0] alu_ctl;
   logic       alu_src;
   logic [1:0] ext_op;
   logic       pc_write, ir_write, mem_write, reg_write;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      cls = C_ILL;
      case (Op)
         6'b000000: begin
            case (Funct)
               6'b100001: cls = C_ADDU;
               6'b100011: cls = C_SUBU;
               6'b000000: cls = C_SLL;
               6'b001000: cls = C_JR;
               default:   cls = C_ILL;
            endcase
         end
         6'b001101: cls = C_ORI;
         6'b001111: cls = C_LUI;
         6'b100011: cls = C_LW;
         6'b101011: cls = C_SW;
         6'b000100: cls = C_BEQ;
         6'b000010: cls = C_J;
         6'b000011: cls = C_JAL;
         default:   cls = C_ILL;
      endcase
   end

   // ALU setup depends only on the instruction, so it naturally holds
   // from EXE through MEM and WB; it is gated by state below.
   always_comb begin
      alu_ctl = 3'b000;
      alu_src = 1'b0;
      ext_op  = 2'd0;
      case (cls)
         C_ADDU:      alu_ctl = 3'b000;
         C_SUBU:      alu_ctl = 3'b001;
         C_SLL:       alu_ctl = 3'b100;
         C_ORI:       begin alu_ctl = 3'b011; alu_src = 1'b1; ext_op = 2'd0; end
         C_LUI:       begin alu_ctl = 3'b011; alu_src = 1'b1; ext_op = 2'd2; end
         C_LW, C_SW:  begin alu_ctl = 3'b000; alu_src = 1'b1; ext_op = 2'd1; end
         C_BEQ:       alu_ctl = 3'b001;
         default:     alu_ctl = 3'b000;
      endcase
   end

   always_comb begin
      state_d    = FETCH;
      ALUControl = 3'b000;
      ALUSrc     = 1'b0;
      ExtOp      = 2'd0;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      PCSrc      = 2'd0;
      RegDst     = 2'd0;
      MemtoReg   = 2'd0;
      case (state_q)
         FETCH: begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = DECODE;
         end
         DECODE: begin
            case (cls)
               C_J:   begin pc_write = 1'b1; PCSrc = 2'd2; end
               C_JR:  begin pc_write = 1'b1; PCSrc = 2'd3; end
               C_JAL: begin
                  pc_write  = 1'b1;
                  PCSrc     = 2'd2;
                  reg_write = 1'b1;
                  RegDst    = 2'd2;
                  MemtoReg  = 2'd2;
               end
               C_ILL:   state_d = FETCH;
               default: state_d = EXE;
            endcase
         end
         EXE: begin
            ALUControl = alu_ctl;
            ALUSrc     = alu_src;
            ExtOp      = ext_op;
            case (cls)
               C_BEQ: begin pc_write = Zero; PCSrc = 2'd1; end
               C_LW, C_SW: state_d = MEM;
               C_ADDU, C_SUBU, C_SLL, C_ORI, C_LUI: state_d = WB;
               default: state_d = FETCH;
            endcase
         end
         MEM: begin
            ALUControl = alu_ctl;
            ALUSrc     = alu_src;
            ExtOp      = ext_op;
            if (cls == C_LW) state_d = WB;
            if (cls == C_SW) mem_write = 1'b1;
         end
         WB: begin
            ALUControl = alu_ctl;
            ALUSrc     = alu_src;
            ExtOp      = ext_op;
            reg_write  = 1'b1;
            if (cls == C_ADDU || cls == C_SUBU || cls == C_SLL) RegDst = 2'd1;
            if (cls == C_LW) MemtoReg = 2'd1;
         end
         default: state_d = FETCH;
      endcase
   end

   // Strobes are forced low for the whole reset window, not just after the edge.
   assign PCWrite  = pc_write  & ~reset;
   assign IRWrite  = ir_write  & ~reset;
   assign MemWrite = mem_write & ~reset;
   assign RegWrite = reg_write & ~reset;
   assign State    = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction expected-output tables fed through a
// scoreboard queue, plus hand sequences for beq Zero and mid-instruction reset.
module tb_mc_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] Op, Funct;
   logic       Zero;
   logic [2:0] ALUControl;
   logic       ALUSrc;
   logic [1:0] ExtOp;
   logic       PCWrite, IRWrite, MemWrite, RegWrite;
   logic [1:0] PCSrc, RegDst, MemtoReg;
   logic [2:0] State;

   mc_ctrl dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
      .ALUControl(ALUControl), .ALUSrc(ALUSrc), .ExtOp(ExtOp),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .PCSrc(PCSrc), .RegDst(RegDst), .MemtoReg(MemtoReg), .State(State)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic [2:0] alu;
      logic       src;
      logic [1:0] ext;
      logic       pcw, irw, mw, rw;
      logic [1:0] pcsrc, rd, m2r;
   } out_t;

   typedef struct {
      string      nm;
      logic [5:0] op, fn;
      logic       z;
      int         n;
      out_t [0:4] e;
   } vec_t;

   int   errors = 0;
   int   checks = 0;
   out_t sbq[$];
   vec_t vt[14];
   out_t FE, DE, Z0;

   function automatic out_t o(input int st, alu, src, ext, pcw, irw, mw, rw, pcsrc, rd, m2r);
      out_t r;
      r.st = 3'(st); r.alu = 3'(alu); r.src = 1'(src); r.ext = 2'(ext);
      r.pcw = 1'(pcw); r.irw = 1'(irw); r.mw = 1'(mw); r.rw = 1'(rw);
      r.pcsrc = 2'(pcsrc); r.rd = 2'(rd); r.m2r = 2'(m2r);
      return r;
   endfunction

   function automatic vec_t mkv(input string nm, input logic [5:0] op, fn, input logic z,
                                input int n, input out_t e1, e2, e3, e4);
      vec_t v;
      v.nm = nm; v.op = op; v.fn = fn; v.z = z; v.n = n;
      v.e[0] = FE; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3; v.e[4] = e4;
      return v;
   endfunction

   function automatic out_t cur();
      out_t r;
      r.st = State; r.alu = ALUControl; r.src = ALUSrc; r.ext = ExtOp;
      r.pcw = PCWrite; r.irw = IRWrite; r.mw = MemWrite; r.rw = RegWrite;
      r.pcsrc = PCSrc; r.rd = RegDst; r.m2r = MemtoReg;
      return r;
   endfunction

   task automatic check_now(input string nm, input out_t exp);
      out_t want, got;
      sbq.push_back(exp);
      got  = cur();
      want = sbq.pop_front();
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got st=%0d alu=%b src=%b ext=%0d pcw=%b irw=%b mw=%b rw=%b pcsrc=%0d rd=%0d m2r=%0d, want st=%0d alu=%b src=%b ext=%0d pcw=%b irw=%b mw=%b rw=%b pcsrc=%0d rd=%0d m2r=%0d",
                  nm, got.st, got.alu, got.src, got.ext, got.pcw, got.irw, got.mw, got.rw,
                  got.pcsrc, got.rd, got.m2r, want.st, want.alu, want.src, want.ext,
                  want.pcw, want.irw, want.mw, want.rw, want.pcsrc, want.rd, want.m2r);
      end
   endtask

   // Called at posedge+1; samples on the following falling edge.
   task automatic step(input string nm, input out_t exp);
      @(negedge clk);
      check_now(nm, exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      FE = o(0, 0,0,0, 1,1,0,0, 0,0,0);
      DE = o(1, 0,0,0, 0,0,0,0, 0,0,0);
      Z0 = o(0, 0,0,0, 0,0,0,0, 0,0,0);
      //             name    op     funct  z  n  cycle1 .. cycle4
      vt[0]  = mkv("addu", 6'h00, 6'h21, 0, 4, DE, o(2,0,0,0,0,0,0,0,0,0,0), o(4,0,0,0,0,0,0,1,0,1,0), Z0);
      vt[1]  = mkv("subu", 6'h00, 6'h23, 0, 4, DE, o(2,1,0,0,0,0,0,0,0,0,0), o(4,1,0,0,0,0,0,1,0,1,0), Z0);
      vt[2]  = mkv("sll",  6'h00, 6'h00, 0, 4, DE, o(2,4,0,0,0,0,0,0,0,0,0), o(4,4,0,0,0,0,0,1,0,1,0), Z0);
      vt[3]  = mkv("ori",  6'h0D, 6'h15, 0, 4, DE, o(2,3,1,0,0,0,0,0,0,0,0), o(4,3,1,0,0,0,0,1,0,0,0), Z0);
      vt[4]  = mkv("lui",  6'h0F, 6'h00, 0, 4, DE, o(2,3,1,2,0,0,0,0,0,0,0), o(4,3,1,2,0,0,0,1,0,0,0), Z0);
      vt[5]  = mkv("lw",   6'h23, 6'h00, 0, 5, DE, o(2,0,1,1,0,0,0,0,0,0,0), o(3,0,1,1,0,0,0,0,0,0,0),
                                                o(4,0,1,1,0,0,0,1,0,0,1));
      vt[6]  = mkv("sw",   6'h2B, 6'h00, 0, 4, DE, o(2,0,1,1,0,0,0,0,0,0,0), o(3,0,1,1,0,0,1,0,0,0,0), Z0);
      vt[7]  = mkv("beq1", 6'h04, 6'h00, 1, 3, DE, o(2,1,0,0,1,0,0,0,1,0,0), Z0, Z0);
      vt[8]  = mkv("beq0", 6'h04, 6'h00, 0, 3, DE, o(2,1,0,0,0,0,0,0,1,0,0), Z0, Z0);
      vt[9]  = mkv("j",    6'h02, 6'h00, 0, 2, o(1,0,0,0,1,0,0,0,2,0,0), Z0, Z0, Z0);
      vt[10] = mkv("jr",   6'h00, 6'h08, 0, 2, o(1,0,0,0,1,0,0,0,3,0,0), Z0, Z0, Z0);
      vt[11] = mkv("jal",  6'h03, 6'h00, 0, 2, o(1,0,0,0,1,0,0,1,2,2,2), Z0, Z0, Z0);
      vt[12] = mkv("illop", 6'h3F, 6'h00, 0, 2, DE, Z0, Z0, Z0);
      vt[13] = mkv("illfn", 6'h00, 6'h3F, 1, 2, DE, Z0, Z0, Z0);

      reset = 1'b1; Op = 6'h3F; Funct = 6'h3F; Zero = 1'b0;
      @(negedge clk);
      check_now("reset_hold", Z0);
      @(posedge clk); #1;
      reset = 1'b0;

      for (int i = 0; i < 14; i++) begin
         Op = vt[i].op; Funct = vt[i].fn; Zero = vt[i].z;
         for (int k = 0; k < vt[i].n; k++)
            step($sformatf("%s_c%0d", vt[i].nm, k), vt[i].e[k]);
      end
      Op = 6'h00; Funct = 6'h21;
      step("after_table_fetch", FE);
      step("after_table_decode", DE);
      step("addu_exe2", o(2,0,0,0,0,0,0,0,0,0,0));
      step("addu_wb2", o(4,0,0,0,0,0,0,1,0,1,0));

      // beq: PCWrite follows Zero combinationally within EXE
      Op = 6'h04; Funct = 6'h00; Zero = 1'b0;
      step("beqz_fetch", FE);
      step("beqz_decode", DE);
      @(negedge clk);
      check_now("beqz_exe_z0", o(2,1,0,0,0,0,0,0,1,0,0));
      Zero = 1'b1; #1;
      check_now("beqz_exe_z1", o(2,1,0,0,1,0,0,0,1,0,0));
      Zero = 1'b0; #1;
      check_now("beqz_exe_z0b", o(2,1,0,0,0,0,0,0,1,0,0));
      @(posedge clk); #1;

      // sw held in MEM, then async reset mid-cycle
      Op = 6'h2B;
      step("swr_fetch", FE);
      step("swr_decode", DE);
      step("swr_exe", o(2,0,1,1,0,0,0,0,0,0,0));
      @(negedge clk);
      check_now("swr_mem", o(3,0,1,1,0,0,1,0,0,0,0));
      #2 reset = 1'b1;
      #1 check_now("swr_async_reset", Z0);
      @(posedge clk); #1;
      check_now("swr_reset_held", Z0);
      @(negedge clk); #1 reset = 1'b0;
      #1 check_now("swr_release_fetch", FE);
      @(posedge clk); #1;
      step("swr_decode2", DE);
      step("swr_exe2", o(2,0,1,1,0,0,0,0,0,0,0));
      step("swr_mem2", o(3,0,1,1,0,0,1,0,0,0,0));
      step("swr_fetch2", FE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got no end by 50000, want finish");
      $fatal(1);
   end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high; forces state FETCH.
REQ-003 SHALL have ports: Op  in  6  instr[31:26]; Funct  in  6  instr[5:0]; both valid from DECODE onward (IR latched at end of FETCH).
REQ-004 SHALL have ports: Zero  in  1  ALU equality flag (SrcA == SrcB).
REQ-005 SHALL have ports: ALUControl  out  3  000 add, 001 sub, 011 or, 100 SrcB<<shamt.
REQ-006 SHALL have ports: ALUSrc  out  1  0 = rt register, 1 = extended imm; ExtOp  out  2  0 zero-ext, 1 sign-ext, 2 imm<<16.
REQ-007 SHALL have ports: PCWrite, IRWrite, MemWrite, RegWrite  out  1 each  write strobes.
REQ-008 SHALL have ports: PCSrc  out  2  0 PC+4, 1 branch target, 2 jump target, 3 rs; RegDst  out  2  0 rt, 1 rd, 2 $31; MemtoReg  out  2  0 ALU, 1 mem data, 2 PC (already PC+4).
REQ-009 SHALL have ports: State  out  3  current state encoding, debug/verification only.

Function
REQ-010 States SHALL be FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4; codes 5-7 SHALL return to FETCH next edge with all strobes 0.
REQ-011 Decoded class: addu(0/100001), subu(0/100011), sll(0/000000), jr(0/001000), ori(001101), lui(001111), lw(100011), sw(101011), beq(000100), j(000010), jal(000011); anything else SHALL be ILLEGAL.
REQ-012 FETCH: IRWrite=1, PCWrite=1, PCSrc=0; next DECODE, unconditionally.
REQ-013 DECODE: j -> PCWrite=1, PCSrc=2, next FETCH; jr -> PCWrite=1, PCSrc=3, next FETCH; jal -> PCWrite=1, PCSrc=2, RegWrite=1, RegDst=2, MemtoReg=2, next FETCH; ILLEGAL -> no strobe, next FETCH; all others -> EXE.
REQ-014 EXE: addu ALUControl=000, subu 001, sll 100 (ALUSrc=0); ori 011 ALUSrc=1 ExtOp=0; lui 011 ALUSrc=1 ExtOp=2; lw/sw 000 ALUSrc=1 ExtOp=1; beq 001 ALUSrc=0.
REQ-015 EXE next: beq -> FETCH, PCWrite=Zero (combinational), PCSrc=1; lw/sw -> MEM; others -> WB.
REQ-016 MEM: lw -> next WB, no strobe; sw -> MemWrite=1, next FETCH.
REQ-017 WB: RegWrite=1; R-type RegDst=1 MemtoReg=0; ori/lui RegDst=0 MemtoReg=0; lw RegDst=0 MemtoReg=1; next FETCH.
REQ-018 ALUControl/ALUSrc/ExtOp SHALL hold their EXE values through MEM and WB for the same instruction; outside EXE/MEM/WB they SHALL be 0.
REQ-019 Strobes not listed for a state SHALL be 0; at most one of MemWrite/RegWrite asserted per cycle.
REQ-020 Cycle counts (FETCH to next FETCH): j/jr/jal/ILLEGAL 2, beq 3, R-type/ori/lui/sw 4, lw 5.
REQ-021 All outputs SHALL be a function of State, Op, Funct and Zero only (Moore except PCWrite in beq EXE).

Reset
REQ-022 Assertion of reset at any time, including mid-instruction, SHALL set State=FETCH asynchronously.
REQ-023 While reset is high, PCWrite, IRWrite, MemWrite, RegWrite SHALL be 0 regardless of state.
REQ-024 First rising edge after reset deassertion SHALL execute FETCH (IRWrite=PCWrite=1 in the cycle following deassertion).

Verification
REQ-025 Op=0,Funct=100001 (addu) -> States 0,1,2,4,0; ALUControl=000 in EXE; WB RegWrite=1, RegDst=1, MemtoReg=0.
REQ-026 Op=100011 (lw) -> States 0,1,2,3,4,0; EXE ALUSrc=1 ExtOp=1 ALUControl=000; WB MemtoReg=1 RegDst=0; MemWrite never 1.
REQ-027 Op=000100 (beq) with Zero=1 -> EXE PCWrite=1 PCSrc=1; repeat with Zero=0 -> PCWrite=0; both return to FETCH after 3 cycles.
REQ-028 Op=000011 (jal) -> DECODE PCWrite=1 PCSrc=2 RegWrite=1 RegDst=2 MemtoReg=2; next State=0.
REQ-029 Op=111111 (illegal) -> States 0,1,0 with all strobes 0 in DECODE.
REQ-030 sw held in MEM, reset pulsed high mid-cycle -> MemWrite drops to 0 immediately, State=0 before next edge; after release, FETCH strobes on next cycle.
